// File: rtl/ascon_sequencer.sv
// Job sequencer for an Ascon AEAD/hash core: walks the init, AD, message or
// hash-squeeze and finalization phases, streams 128-bit blocks, reports done/error.
module ascon_sequencer #(
  parameter int HASH_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   cfg_mode,
  input  logic [1:0]   cfg_sel_type,
  input  logic [31:0]  cfg_ad_len,
  input  logic [31:0]  cfg_msg_len,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic [127:0] tag_out,
  output logic         busy,
  output logic         job_done,
  output logic         job_err,
  output logic [1:0]   core_sel_type,
  output logic         core_mode_dec,
  output logic [31:0]  core_data_length,
  output logic [31:0]  core_data_position,
  output logic [127:0] core_data_in,
  output logic         core_en_init,
  output logic         core_en_ad,
  output logic         core_en_ed,
  output logic         core_en_hash,
  output logic         core_en_final,
  input  logic [127:0] core_data_out,
  input  logic [127:0] core_tag,
  input  logic         core_done,
  input  logic         core_err
);

  typedef enum logic [3:0] {
    IDLE, INIT, AD_REQ, AD_WAIT, MSG_REQ, MSG_WAIT, MSG_OUT,
    HASH_REQ, HASH_WAIT, HASH_OUT, FINAL, DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_HASH = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam logic [31:0] HASH_WORDS_C = 32'(HASH_WORDS);

  // ceil(len/16) with a 33-bit sum so len=FFFFFFFF does not wrap to zero.
  function automatic logic [31:0] block_count(input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, len} + 33'd15;
    return {3'b000, sum[32:4]};
  endfunction

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [1:0]    sel_q, sel_d;
  logic [31:0]   ad_len_q, ad_len_d;
  logic [31:0]   msg_len_q, msg_len_d;
  logic [31:0]   ad_blk_q, ad_blk_d;
  logic [31:0]   msg_blk_q, msg_blk_d;
  logic [31:0]   idx_q, idx_d;
  logic          wait_q, wait_d;
  logic [127:0]  din_q, din_d;
  logic [127:0]  dout_q, dout_d;
  logic          ovalid_q, ovalid_d;
  logic [127:0]  tag_q, tag_d;
  logic          err_q, err_d;

  logic          any_en;
  logic          timeout;
  logic          abort;
  logic [31:0]   idx_inc;

  // Core enables decode straight from the state, so only one can ever be high.
  assign core_en_init  = (state_q == INIT);
  assign core_en_ad    = (state_q == AD_WAIT);
  assign core_en_ed    = (state_q == MSG_WAIT);
  assign core_en_hash  = (state_q == HASH_WAIT);
  assign core_en_final = (state_q == FINAL);

  assign any_en  = core_en_init | core_en_ad | core_en_ed | core_en_hash | core_en_final;
  // wait_q marks the second WAIT cycle; no core_done by then is a hang.
  assign timeout = (core_en_ad | core_en_ed | core_en_hash) & wait_q & ~core_done;
  assign abort   = (core_err & any_en) | timeout;
  assign idx_inc = idx_q + 32'd1;

  assign in_ready      = (state_q == AD_REQ) || (state_q == MSG_REQ);
  assign out_valid     = ovalid_q;
  assign out_data      = dout_q;
  assign tag_out       = tag_q;
  assign busy          = (state_q != IDLE);
  assign job_done      = (state_q == DONE);
  assign job_err       = err_q;
  assign core_sel_type = sel_q;
  assign core_mode_dec = (mode_q == MODE_DEC);
  assign core_data_in  = din_q;

  assign core_data_position = (idx_q[31:28] != 4'h0) ? 32'hFFFF_FFF0 : {idx_q[27:0], 4'h0};

  always_comb begin
    core_data_length = '0;
    case (state_q)
      INIT, AD_REQ, AD_WAIT: core_data_length = ad_len_q;
      MSG_REQ, MSG_WAIT, MSG_OUT, HASH_REQ, HASH_WAIT, HASH_OUT, FINAL:
        core_data_length = msg_len_q;
      default: core_data_length = '0;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d   = state_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    ad_len_d  = ad_len_q;
    msg_len_d = msg_len_q;
    ad_blk_d  = ad_blk_q;
    msg_blk_d = msg_blk_q;
    idx_d     = idx_q;
    wait_d    = 1'b0;
    din_d     = din_q;
    dout_d    = dout_q;
    ovalid_d  = ovalid_q;
    tag_d     = tag_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode_e'(cfg_mode) == MODE_RSVD) begin
            err_d = 1'b1;
          end else begin
            mode_d    = mode_e'(cfg_mode);
            sel_d     = cfg_sel_type;
            ad_len_d  = cfg_ad_len;
            msg_len_d = cfg_msg_len;
            ad_blk_d  = block_count(cfg_ad_len);
            msg_blk_d = block_count(cfg_msg_len);
            idx_d     = '0;
            tag_d     = '0;
            state_d   = INIT;
          end
        end
      end
      INIT: begin
        if (mode_q == MODE_HASH)    state_d = HASH_REQ;
        else if (ad_blk_q != '0)    state_d = AD_REQ;
        else if (msg_blk_q != '0)   state_d = MSG_REQ;
        else                        state_d = FINAL;
      end
      AD_REQ: begin
        if (in_valid) begin
          din_d   = in_data;
          state_d = AD_WAIT;
        end
      end
      AD_WAIT: begin
        if (core_done) begin
          if (idx_inc == ad_blk_q) begin
            idx_d   = '0;
            state_d = (msg_blk_q != '0) ? MSG_REQ : FINAL;
          end else begin
            idx_d   = idx_inc;
            state_d = AD_REQ;
          end
        end else begin
          wait_d = 1'b1;
        end
      end
      MSG_REQ: begin
        if (in_valid) begin
          din_d   = in_data;
          state_d = MSG_WAIT;
        end
      end
      MSG_WAIT: begin
        if (core_done) state_d = MSG_OUT;
        else           wait_d  = 1'b1;
      end
      HASH_REQ: state_d = HASH_WAIT;
      HASH_WAIT: begin
        if (core_done) state_d = HASH_OUT;
        else           wait_d  = 1'b1;
      end
      MSG_OUT, HASH_OUT: begin
        // The core output register is valid the cycle after core_done.
        if (!ovalid_q) begin
          dout_d   = (state_q == HASH_OUT) ? {core_data_out[127:64], 64'h0} : core_data_out;
          ovalid_d = 1'b1;
        end else if (out_ready) begin
          ovalid_d = 1'b0;
          if (state_q == MSG_OUT) begin
            if (idx_inc == msg_blk_q) begin
              idx_d   = '0;
              state_d = FINAL;
            end else begin
              idx_d   = idx_inc;
              state_d = MSG_REQ;
            end
          end else begin
            if (idx_inc == HASH_WORDS_C) begin
              idx_d   = '0;
              state_d = FINAL;
            end else begin
              idx_d   = idx_inc;
              state_d = HASH_REQ;
            end
          end
        end
      end
      FINAL: begin
        tag_d   = core_tag;
        state_d = DONE;
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d  = IDLE;
      err_d    = 1'b1;
      ovalid_d = 1'b0;
      idx_d    = '0;
      wait_d   = 1'b0;
      tag_d    = tag_q;
    end
  end

  // NOTE: the data registers are reset as well because every output, including
  // tag_out and core_data_in, must read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_ENC;
      sel_q     <= '0;
      ad_len_q  <= '0;
      msg_len_q <= '0;
      ad_blk_q  <= '0;
      msg_blk_q <= '0;
      idx_q     <= '0;
      wait_q    <= 1'b0;
      din_q     <= '0;
      dout_q    <= '0;
      ovalid_q  <= 1'b0;
      tag_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      ad_len_q  <= ad_len_d;
      msg_len_q <= msg_len_d;
      ad_blk_q  <= ad_blk_d;
      msg_blk_q <= msg_blk_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      ovalid_q  <= ovalid_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ascon_sequencer.sv
// Directed bench for ascon_sequencer: a small behavioural core answers the
// enables, a monitor logs enable activity, one initial block steps the jobs.
module tb_ascon_sequencer;

  localparam logic [127:0] MASK  = 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
  localparam logic [127:0] TAG1  = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [127:0] TAG2  = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210;
  localparam logic [63:0]  HBASE = 64'h0123_4567_89AB_CD00;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   cfg_mode;
  logic [1:0]   cfg_sel_type;
  logic [31:0]  cfg_ad_len;
  logic [31:0]  cfg_msg_len;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic [127:0] tag_out;
  logic         busy;
  logic         job_done;
  logic         job_err;
  logic [1:0]   core_sel_type;
  logic         core_mode_dec;
  logic [31:0]  core_data_length;
  logic [31:0]  core_data_position;
  logic [127:0] core_data_in;
  logic         core_en_init;
  logic         core_en_ad;
  logic         core_en_ed;
  logic         core_en_hash;
  logic         core_en_final;
  logic [127:0] core_data_out;
  logic [127:0] core_tag;
  logic         core_done;
  logic         core_err;

  logic stall_done;
  logic err_inject;

  int errors = 0;
  int checks = 0;

  ascon_sequencer #(.HASH_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
    .cfg_sel_type(cfg_sel_type), .cfg_ad_len(cfg_ad_len), .cfg_msg_len(cfg_msg_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .tag_out(tag_out), .busy(busy), .job_done(job_done), .job_err(job_err),
    .core_sel_type(core_sel_type), .core_mode_dec(core_mode_dec),
    .core_data_length(core_data_length), .core_data_position(core_data_position),
    .core_data_in(core_data_in), .core_en_init(core_en_init), .core_en_ad(core_en_ad),
    .core_en_ed(core_en_ed), .core_en_hash(core_en_hash), .core_en_final(core_en_final),
    .core_data_out(core_data_out), .core_tag(core_tag), .core_done(core_done),
    .core_err(core_err)
  );

  always #5 clk = ~clk;

  // Behavioural core: done in the second enable cycle, data one cycle later.
  int           cyc = 0;
  int           hcnt = 0;
  logic         push = 1'b0;
  logic [127:0] pending = '0;
  initial begin
    core_done = 1'b0;
    core_err = 1'b0;
    core_data_out = '0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      core_done = 1'b0; core_err = 1'b0; cyc = 0; hcnt = 0; push = 1'b0;
    end else begin
      if (core_en_init) hcnt = 0;
      if (push) begin core_data_out = pending; push = 1'b0; end
      core_done = 1'b0;
      core_err = 1'b0;
      if (core_en_ad | core_en_ed | core_en_hash) begin
        cyc++;
        if (err_inject) core_err = 1'b1;
        else if (cyc == 2 && !stall_done) begin
          core_done = 1'b1;
          push = 1'b1;
          core_data_out = {4{32'hDEAD_BEEF}};
          pending = core_en_hash ? {HBASE + 64'(hcnt), 64'hFFFF_FFFF_FFFF_FFFF}
                                 : core_data_in ^ MASK;
          if (core_en_hash) hcnt++;
        end
      end else begin
        cyc = 0;
      end
    end
  end

  // Cumulative activity log; the stimulus takes deltas around each job.
  int n_init = 0, n_final = 0, n_ad = 0, n_ed = 0, n_hash = 0;
  int n_inrdy = 0, n_done = 0, n_multi = 0;
  logic p_ad = 1'b0, p_ed = 1'b0, p_hash = 1'b0;
  logic [31:0] ad_pos[$];
  logic [31:0] ed_pos[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_en_init)  n_init++;
      if (core_en_final) n_final++;
      if (core_en_ad && !p_ad) begin n_ad++; ad_pos.push_back(core_data_position); end
      if (core_en_ed && !p_ed) begin n_ed++; ed_pos.push_back(core_data_position); end
      if (core_en_hash && !p_hash) n_hash++;
      if ($countones({core_en_init, core_en_ad, core_en_ed, core_en_hash, core_en_final}) > 1)
        n_multi++;
      if (in_ready) n_inrdy++;
      if (job_done) n_done++;
    end
    p_ad = core_en_ad; p_ed = core_en_ed; p_hash = core_en_hash;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [1:0] mode, input logic [1:0] sel,
                           input logic [31:0] ad_len, input logic [31:0] msg_len);
    start = 1'b1; cfg_mode = mode; cfg_sel_type = sel;
    cfg_ad_len = ad_len; cfg_msg_len = msg_len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input string tag);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check(tag, {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_beat(input logic [127:0] exp, input string tag);
    int n = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    check(tag, out_data, exp);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (job_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check(tag, {127'd0, job_done}, 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_init, b_final, b_ad, b_ed, b_hash, b_inrdy, b_done, h0;
    logic [127:0] exp;

    rst_n = 1'b0; start = 1'b0; cfg_mode = '0; cfg_sel_type = '0;
    cfg_ad_len = '0; cfg_msg_len = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; core_tag = TAG1; stall_done = 1'b0; err_inject = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_tag", tag_out, 128'd0);
    check("rst_enables", {123'd0, core_en_init, core_en_ad, core_en_ed, core_en_hash, core_en_final}, 128'd0);
    check("rst_flags", {126'd0, job_done, job_err}, 128'd0);
    check("rst_len_pos", {64'd0, core_data_length, core_data_position}, 128'd0);

    // Encrypt, 1 AD block, 2 message blocks
    b_init = n_init; b_final = n_final; b_ad = n_ad; b_ed = n_ed; b_done = n_done;
    start_job(2'd0, 2'd2, 32'd16, 32'd32);
    check("enc_init", {127'd0, core_en_init}, 128'd1);
    check("enc_busy", {127'd0, busy}, 128'd1);
    check("enc_sel", {126'd0, core_sel_type}, 128'd2);
    check("enc_mode_dec", {127'd0, core_mode_dec}, 128'd0);
    @(negedge clk);
    check("enc_ad_len", {96'd0, core_data_length}, 128'd16);
    send_block(128'h1111_2222_3333_4444_5555_6666_7777_8888, "enc_ad_req");
    check("enc_ad_en", {127'd0, core_en_ad}, 128'd1);
    check("enc_ad_din", core_data_in, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    send_block(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, "enc_m0_req");
    check("enc_m0_en", {127'd0, core_en_ed}, 128'd1);
    check("enc_m0_len", {96'd0, core_data_length}, 128'd32);
    check("enc_m0_pos", {96'd0, core_data_position}, 128'd0);
    recv_beat(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 ^ MASK, "enc_beat0");
    send_block(128'hCAFE_F00D_0000_0001_0000_0002_0000_0003, "enc_m1_req");
    check("enc_m1_pos", {96'd0, core_data_position}, 128'd16);
    recv_beat(128'hCAFE_F00D_0000_0001_0000_0002_0000_0003 ^ MASK, "enc_beat1");
    wait_done("enc_done");
    check("enc_tag", tag_out, TAG1);
    @(negedge clk);
    check("enc_idle", {126'd0, busy, job_done}, 128'd0);
    check("enc_init_cycles", 128'(n_init - b_init), 128'd1);
    check("enc_ad_ops", 128'(n_ad - b_ad), 128'd1);
    check("enc_ed_ops", 128'(n_ed - b_ed), 128'd2);
    check("enc_final_cycles", 128'(n_final - b_final), 128'd1);
    check("enc_done_cycles", 128'(n_done - b_done), 128'd1);
    check("enc_ad_pos0", {96'd0, ad_pos[b_ad]}, 128'd0);
    check("enc_ed_pos0", {96'd0, ed_pos[b_ed]}, 128'd0);
    check("enc_ed_pos1", {96'd0, ed_pos[b_ed + 1]}, 128'd16);

    // Empty encrypt: INIT straight to FINAL
    core_tag = TAG2;
    b_inrdy = n_inrdy;
    start_job(2'd0, 2'd0, 32'd0, 32'd0);
    check("empty_init", {127'd0, core_en_init}, 128'd1);
    @(negedge clk);
    check("empty_final", {127'd0, core_en_final}, 128'd1);
    @(negedge clk);
    check("empty_done", {127'd0, job_done}, 128'd1);
    check("empty_tag", tag_out, TAG2);
    core_tag = '0;
    repeat (3) @(negedge clk);
    check("empty_tag_hold", tag_out, TAG2);
    check("empty_no_in_ready", 128'(n_inrdy - b_inrdy), 128'd0);

    // Hash, 4 squeeze words, back-pressure on the third beat
    b_hash = n_hash; b_inrdy = n_inrdy; b_ed = n_ed;
    start_job(2'd2, 2'd1, 32'd5, 32'd7);
    for (int b = 0; b < 4; b++) begin
      exp = {HBASE + 64'(b), 64'd0};
      if (b == 2) begin
        int n = 0;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("hash_stall_valid", {127'd0, out_valid}, 128'd1);
        h0 = n_hash;
        for (int i = 0; i < 5; i++) begin
          check("hash_stall_data", out_data, exp);
          @(negedge clk);
        end
        check("hash_stall_held", {127'd0, out_valid}, 128'd1);
        check("hash_stall_no_op", 128'(n_hash - h0), 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end else begin
        recv_beat(exp, "hash_beat");
      end
    end
    wait_done("hash_done");
    @(negedge clk);
    check("hash_ops", 128'(n_hash - b_hash), 128'd4);
    check("hash_no_in_ready", 128'(n_inrdy - b_inrdy), 128'd0);
    check("hash_no_ed", 128'(n_ed - b_ed), 128'd0);

    // Core never answers during AD_WAIT
    stall_done = 1'b1;
    start_job(2'd0, 2'd0, 32'd16, 32'd0);
    send_block(128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, "to_ad_req");
    check("to_w0", {126'd0, core_en_ad, job_err}, 128'd2);
    @(negedge clk);
    check("to_w1", {126'd0, core_en_ad, job_err}, 128'd2);
    @(negedge clk);
    check("to_err", {127'd0, job_err}, 128'd1);
    check("to_idle", {123'd0, busy, core_en_ad, core_en_ed, core_en_init, core_en_final}, 128'd0);
    @(negedge clk);
    check("to_err_pulse", {127'd0, job_err}, 128'd0);
    stall_done = 1'b0;

    // core_err during MSG_WAIT aborts
    err_inject = 1'b1;
    start_job(2'd0, 2'd0, 32'd0, 32'd16);
    send_block(128'h7777_0000_7777_0000_7777_0000_7777_0000, "cerr_req");
    @(negedge clk);
    check("cerr_err", {127'd0, job_err}, 128'd1);
    check("cerr_idle", {124'd0, busy, core_en_ed, out_valid, core_en_final}, 128'd0);
    err_inject = 1'b0;
    @(negedge clk);

    // Asynchronous reset in MSG_WAIT
    stall_done = 1'b1;
    start_job(2'd1, 2'd3, 32'd0, 32'd16);
    check("rw_mode_dec", {127'd0, core_mode_dec}, 128'd1);
    send_block(128'h9999_8888_7777_6666_5555_4444_3333_2222, "rw_req");
    check("rw_ed", {127'd0, core_en_ed}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_ctrl_zero", {121'd0, busy, core_en_ed, core_mode_dec, in_ready, out_valid, job_err, job_done}, 128'd0);
    check("rw_din_zero", core_data_in, 128'd0);
    check("rw_sel_len_zero", {94'd0, core_sel_type, core_data_length}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_done = 1'b0;
    @(negedge clk);

    // Clean decrypt after reset; stray start while busy; msg_len=17
    core_tag = TAG1;
    b_ed = n_ed;
    start_job(2'd1, 2'd0, 32'd16, 32'd17);
    check("dec_mode_dec", {127'd0, core_mode_dec}, 128'd1);
    @(negedge clk);
    start = 1'b1; cfg_mode = 2'd2;
    send_block(128'h4444_3333_2222_1111_0000_FFFF_EEEE_DDDD, "dec_ad_req");
    start = 1'b0;
    check("dec_ignore_start", {126'd0, core_en_ad, core_mode_dec}, 128'd3);
    send_block(128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111, "dec_m0_req");
    check("dec_m0_len", {96'd0, core_data_length}, 128'd17);
    recv_beat(128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111 ^ MASK, "dec_beat0");
    send_block(128'h0000_0000_0000_0000_0000_0000_0000_00AB, "dec_m1_req");
    recv_beat(128'h0000_0000_0000_0000_0000_0000_0000_00AB ^ MASK, "dec_beat1");
    wait_done("dec_done");
    check("dec_tag", tag_out, TAG1);
    @(negedge clk);
    check("dec_ed_ops", 128'(n_ed - b_ed), 128'd2);
    check("dec_ed_pos0", {96'd0, ed_pos[b_ed]}, 128'd0);
    check("dec_ed_pos1", {96'd0, ed_pos[b_ed + 1]}, 128'd16);

    // Reserved mode
    start_job(2'd3, 2'd0, 32'd16, 32'd16);
    check("rsvd_err", {127'd0, job_err}, 128'd1);
    check("rsvd_idle", {126'd0, busy, core_en_init}, 128'd0);
    @(negedge clk);
    check("rsvd_pulse", {126'd0, job_err, busy}, 128'd0);

    check("never_multi_enable", 128'(n_multi), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
